// File: rtl/mux_81.sv
// 8:1 lane multiplexer built as a three-level tree of 2:1 cells, plus registered copies of result and select.
// Latency: y is combinational (0 cycles) by default, 1 cycle with MUX81_REG_OUT_EN; y_q/x_q are always 1 cycle.
// Backpressure: none; free-running datapath that captures every rising clk edge with no enable or handshake.

module mux_21 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] o
);

    assign o = s ? b : a;

endmodule

module mux_81 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*WIDTH-1:0] d,
    input  logic [2:0]         x,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   y_q,
    output logic [2:0]         x_q
);

    logic [WIDTH-1:0] lane [8];
    logic [WIDTH-1:0] m0   [4];
    logic [WIDTH-1:0] m1   [2];
    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] y_d;
    logic [2:0]       x_d;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane[i] = d[i*WIDTH +: WIDTH];
    end

    // Level 0 pairs adjacent lanes on x[0]; each later level halves the candidates.
    for (genvar k = 0; k < 4; k++) begin : g_l0
        mux_21 #(.WIDTH(WIDTH)) u_cell (
            .a (lane[2*k]),
            .b (lane[2*k+1]),
            .s (x[0]),
            .o (m0[k])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_l1
        mux_21 #(.WIDTH(WIDTH)) u_cell (
            .a (m0[2*j]),
            .b (m0[2*j+1]),
            .s (x[1]),
            .o (m1[j])
        );
    end

    mux_21 #(.WIDTH(WIDTH)) u_l2 (
        .a (m1[0]),
        .b (m1[1]),
        .s (x[2]),
        .o (out_w)
    );

    always_comb begin
        y_d = out_w;
        x_d = x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
            x_q <= 3'b000;
        end else begin
            y_q <= y_d;
            x_q <= x_d;
        end
    end

`ifdef MUX81_REG_OUT_EN
    assign y = y_q;
`else
    assign y = out_w;
`endif

endmodule

// File: tb/tb_mux_81.sv
// Scoreboarded bench for mux_81 at WIDTH=1 and WIDTH=4 with a shift-and-mask lane model.
module tb_mux_81;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  d1 = '0;
    logic [2:0]  x1 = '0;
    logic        y1, y1q;
    logic [2:0]  x1q;
    logic [31:0] d4 = '0;
    logic [2:0]  x4 = '0;
    logic [3:0]  y4, y4q;
    logic [2:0]  x4q;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] y;
        logic [2:0] x;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    always #25 clk = ~clk;

    mux_81 #(.WIDTH(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .d (d1), .x (x1),
        .y (y1), .y_q (y1q), .x_q (x1q)
    );

    mux_81 #(.WIDTH(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .d (d4), .x (x4),
        .y (y4), .y_q (y4q), .x_q (x4q)
    );

    function automatic logic [3:0] model(input logic [31:0] dd, input logic [2:0] sel, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 4'((dd >> (int'(sel) * w)) & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive both instances now; expected captures go to the scoreboard for the next edge.
    task automatic drive(input logic [7:0] a1, input logic [2:0] s1,
                         input logic [31:0] a4, input logic [2:0] s4);
        d1 = a1;
        x1 = s1;
        d4 = a4;
        x4 = s4;
        q1.push_back('{model({24'd0, a1}, s1, 1), s1});
        q4.push_back('{model(a4, s4, 4), s4});
        #1;
`ifndef MUX81_REG_OUT_EN
        check("comb_y_w1", {31'd0, y1}, {28'd0, model({24'd0, a1}, s1, 1)});
        check("comb_y_w4", {28'd0, y4}, {28'd0, model(a4, s4, 4)});
`endif
    endtask

    task automatic apply(input logic [7:0] a1, input logic [2:0] s1,
                         input logic [31:0] a4, input logic [2:0] s4);
        @(negedge clk);
        drive(a1, s1, a4, s4);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("y_q_w1", {31'd0, y1q}, {28'd0, e.y});
                check("x_q_w1", {29'd0, x1q}, {29'd0, e.x});
`ifdef MUX81_REG_OUT_EN
                check("y_reg_w1", {31'd0, y1}, {28'd0, e.y});
`endif
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("y_q_w4", {28'd0, y4q}, {28'd0, e.y});
                check("x_q_w4", {29'd0, x4q}, {29'd0, e.x});
`ifdef MUX81_REG_OUT_EN
                check("y_reg_w4", {28'd0, y4}, {28'd0, e.y});
`endif
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1;
        check("rst_y_q_w1", {31'd0, y1q}, 32'd0);
        check("rst_x_q_w1", {29'd0, x1q}, 32'd0);
        check("rst_y_q_w4", {28'd0, y4q}, 32'd0);
`ifdef MUX81_REG_OUT_EN
        check("rst_y_w1", {31'd0, y1}, 32'd0);
`endif
        #9;
        rst_n = 1'b1;

        for (int s = 0; s < 8; s++)
            apply(8'b01100110, 3'(s), 32'h76543210, 3'(s));

`ifndef MUX81_REG_OUT_EN
        @(negedge clk);
        drive(8'b01100110, 3'd5, 32'h76543210, 3'd5);
        check("w4_x5_const", {28'd0, y4}, 32'h5);
        @(negedge clk);
        drive(8'b01100110, 3'd7, 32'h76543210, 3'd7);
        check("w4_x7_const", {28'd0, y4}, 32'h7);
        check("sweep_x7_const", {31'd0, y1}, 32'd0);
`endif

        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                apply(8'd1 << i, 3'(j), 32'hF << (4 * i), 3'(j));

        for (int n = 0; n < 40; n++)
            apply(8'($urandom), 3'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)));

        apply(8'h08, 3'd3, 32'h0000_9000, 3'd3);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_y_q_w1", {31'd0, y1q}, 32'd0);
        check("midrst_x_q_w1", {29'd0, x1q}, 32'd0);
        check("midrst_y_q_w4", {28'd0, y4q}, 32'd0);
        check("midrst_x_q_w4", {29'd0, x4q}, 32'd0);
`ifdef MUX81_REG_OUT_EN
        check("midrst_y_w1", {31'd0, y1}, 32'd0);
`endif
        @(posedge clk);
        #1;
        check("rst_hold_y_q_w4", {28'd0, y4q}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h80, 3'd7, 32'hA000_0000, 3'd7);

        for (int n = 0; n < 20; n++)
            apply(8'($urandom), 3'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q1.size() + q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
